// File: rtl/counter_sched_if.sv
// counter_sched_if: requester/counter-facing signal bundle of the counter
// scheduler. The slave modport is the scheduler itself; the master modport is
// the environment (requesters plus the shared counter's output).
interface counter_sched_if #(
  parameter int NREQ = 4,
  parameter int CW   = 4
) ();
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] target;
  logic [CW-1:0]      cnt_in;
  logic               cnt_clr;
  logic               cnt_en;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic               err;

  modport master (
    output req, target, cnt_in,
    input  cnt_clr, cnt_en, grant, done, busy, err
  );

  modport slave (
    input  req, target, cnt_in,
    output cnt_clr, cnt_en, grant, done, busy, err
  );
endinterface

// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler sharing one 4-bit up-counter among
// NREQ requesters. The owner's target is latched at grant, the counter is
// cleared for one cycle, enabled until it matches the target, then the owner
// gets a one-cycle done pulse.
// Optional feature macro: COUNTER_SCHED_WATCHDOG_EN -- adds a RUN-cycle
// watchdog that pulses err and abandons the grant if the counter never
// reaches the target. Without it err is tied low and RUN waits forever.
module counter_sched #(
  parameter int NREQ = 4,
  parameter int CW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  counter_sched_if.slave   bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

`ifdef COUNTER_SCHED_WATCHDOG_EN
  // RUN may last at most 2^CW+1 cycles (counter 0..2^CW-1 plus the match
  // cycle); the counter value 2^CW marks the last allowed RUN cycle.
  localparam logic [CW+1:0] WD_LIMIT = {2'b01, {CW{1'b0}}};
`endif

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   own_q, own_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            clr_q, clr_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   tgt_q;
  logic [CW-1:0]   tgt_sel;
  logic            tgt_ld;

  logic [NREQ-1:0] rot;
  logic [IW:0]     win_sum;
  logic [IW-1:0]   win_idx;
  logic            win_found;
  logic            own_req;
  logic            match;
  logic            timeout;

`ifdef COUNTER_SCHED_WATCHDOG_EN
  logic [CW+1:0]   wd_q, wd_d;
  logic            err_q, err_d;
`endif

  // Index of the requester after i, wrapping at NREQ.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    logic [IW:0] n;
    n = {1'b0, i} + 1'b1;
    return (n == NREQ_W) ? '0 : n[IW-1:0];
  endfunction

  assign own_req = bus.req[own_q];
  assign match   = (bus.cnt_in == tgt_q);

`ifdef COUNTER_SCHED_WATCHDOG_EN
  assign timeout = (state_q == S_RUN) && (wd_q == WD_LIMIT);
`else
  assign timeout = 1'b0;
`endif

  // Round-robin pick: rotate requests so the search start sits at bit 0,
  // take the lowest set bit, then map it back to an absolute index.
  always_comb begin
    rot       = (bus.req >> ptr_q) | (bus.req << (NREQ_W - {1'b0, ptr_q}));
    win_found = 1'b0;
    win_sum   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        win_found = 1'b1;
        win_sum   = {1'b0, ptr_q} + (IW+1)'(k);
      end
    end
    win_idx = (win_sum >= NREQ_W) ? IW'(win_sum - NREQ_W) : IW'(win_sum);
  end

  // Select the winner's target slice for latching at grant time.
  always_comb begin
    tgt_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) tgt_sel = bus.target[i*CW +: CW];
    end
  end

  // Scheduler next-state logic: grant, clear, run, complete or abort.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    done_d  = '0;
    clr_d   = 1'b0;
    tgt_ld  = 1'b0;
`ifdef COUNTER_SCHED_WATCHDOG_EN
    wd_d    = wd_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d          = S_CLEAR;
          own_d            = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          clr_d            = 1'b1;
          tgt_ld           = 1'b1;
`ifdef COUNTER_SCHED_WATCHDOG_EN
          wd_d             = '0;
`endif
        end
      end
      S_CLEAR: begin
        if (!own_req) begin
          // Owner withdrew before counting started.
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = next_idx(own_q);
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!own_req) begin
          // Owner withdrew mid-count: release without a done pulse.
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = next_idx(own_q);
        end else if (match) begin
          state_d       = S_DONE;
          done_d[own_q] = 1'b1;
        end
`ifdef COUNTER_SCHED_WATCHDOG_EN
        else if (timeout) begin
          // Counter never reached the target: give up on this owner.
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = next_idx(own_q);
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        ptr_d   = next_idx(own_q);
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Control registers; reset returns to IDLE and restarts the search at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      own_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
    end
  end

  // Target is data: captured once per grant, never reset.
  always_ff @(posedge clk) begin
    if (tgt_ld) tgt_q <= tgt_sel;
  end

`ifdef COUNTER_SCHED_WATCHDOG_EN
  // Watchdog RUN-cycle counter and its one-cycle error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // Enable is combinational so an abort or match stops the counter at once.
  assign bus.cnt_en  = (state_q == S_RUN) && own_req && !match && !timeout;
  assign bus.cnt_clr = clr_q;
  assign bus.grant   = grant_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;

endmodule
